// File: rtl/oneapi_avalon_to_axi_gasket.sv
// Avalon-ST sink to AXI4-Stream source: channel repack, sop/eop framing, 2-entry skid buffer.
// Optional protocol error reporting is enabled by defining ONEAPI_A2X_PROTOCOL_CHECK_EN.
`timescale 1ns/1ps
module oneapi_avalon_to_axi_gasket #(
    parameter int PARALLEL_PIXELS      = 1,
    parameter int CHANNELS             = 3,
    parameter int BITS_PER_CHANNEL_AV  = 8,
    parameter int BITS_PER_PIXEL_AV    = 24,
    parameter int BITS_AV              = 24,
    parameter int EMPTY_BITS           = 2,
    parameter int BITS_PER_CHANNEL_AXI = 8,
    parameter int BITS_PER_PIXEL_AXI   = 24,
    parameter int BITS_AXI             = 24,
    parameter int TUSER_BITS           = 3
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset_n,
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
    output logic                  err_orphan,
    output logic                  err_missing_eop,
    output logic [15:0]           drop_count,
`endif
    output logic                  asi_ready,
    input  logic                  asi_valid,
    input  logic [BITS_AV-1:0]    asi_data,
    input  logic                  asi_startofpacket,
    input  logic                  asi_endofpacket,
    input  logic [EMPTY_BITS-1:0] asi_empty,
    input  logic                  axm_tready,
    output logic                  axm_tvalid,
    output logic [BITS_AXI-1:0]   axm_tdata,
    output logic                  axm_tlast,
    output logic [TUSER_BITS-1:0] axm_tuser
);

    typedef enum logic {WAIT_SOP = 1'b0, IN_PKT = 1'b1} state_t;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  out_vld_q, out_vld_d;
    logic [BITS_AXI-1:0]   out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [TUSER_BITS-1:0] out_user_q, out_user_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [BITS_AXI-1:0]   skid_data_q, skid_data_d;
    logic                  skid_last_q, skid_last_d;
    logic [TUSER_BITS-1:0] skid_user_q, skid_user_d;

    logic                  accept, fwd, pop, out_free;
    logic [BITS_AXI-1:0]   in_data;
    logic [TUSER_BITS-1:0] in_user;
    logic                  unused_empty;

    function automatic logic [BITS_AXI-1:0] repack(input logic [BITS_AV-1:0] d);
        logic [BITS_AXI-1:0] r;
        r = '0;
        for (int p = 0; p < PARALLEL_PIXELS; p++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL_AXI] =
                    BITS_PER_CHANNEL_AXI'(d[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL_AV]);
            end
        end
        return r;
    endfunction

    // Beats outside a packet are consumed but never enter the buffer.
    assign accept       = asi_valid & ready_q;
    assign fwd          = accept & ((state_q == IN_PKT) | asi_startofpacket);
    assign pop          = out_vld_q & axm_tready;
    assign out_free     = ~out_vld_q | pop;
    assign in_data      = repack(asi_data);
    assign unused_empty = ^asi_empty;

    always_comb begin
        in_user    = '0;
        in_user[0] = asi_startofpacket;
    end

    always_comb begin
        state_d = state_q;
        if (fwd) begin
            state_d = asi_endofpacket ? WAIT_SOP : IN_PKT;
        end
    end

    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        skid_user_d = skid_user_q;
        if (out_free) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = skid_data_q;
                out_last_d = skid_last_q;
                out_user_d = skid_user_q;
                skid_vld_d = fwd;
                if (fwd) begin
                    skid_data_d = in_data;
                    skid_last_d = asi_endofpacket;
                    skid_user_d = in_user;
                end
            end else begin
                out_vld_d = fwd;
                if (fwd) begin
                    out_data_d = in_data;
                    out_last_d = asi_endofpacket;
                    out_user_d = in_user;
                end
            end
        end else if (fwd) begin
            skid_vld_d  = 1'b1;
            skid_data_d = in_data;
            skid_last_d = asi_endofpacket;
            skid_user_d = in_user;
        end
        // Ready depends only on next-cycle occupancy, never on axm_tready.
        ready_d = ~(out_vld_d & skid_vld_d);
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            state_q     <= WAIT_SOP;
            ready_q     <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            skid_user_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            skid_user_q <= skid_user_d;
        end
    end

    assign asi_ready  = ready_q;
    assign axm_tvalid = out_vld_q;
    assign axm_tdata  = out_data_q;
    assign axm_tlast  = out_last_q;
    assign axm_tuser  = out_user_q;

`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
    logic        err_orphan_q, err_missing_eop_q;
    logic [15:0] drop_count_q;
    logic        dropped, missing_eop;

    assign dropped     = accept & ~fwd;
    assign missing_eop = accept & asi_startofpacket & (state_q == IN_PKT);

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            err_orphan_q      <= 1'b0;
            err_missing_eop_q <= 1'b0;
            drop_count_q      <= '0;
        end else begin
            if (dropped) begin
                err_orphan_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_q <= drop_count_q + 16'd1;
                end
            end
            if (missing_eop) begin
                err_missing_eop_q <= 1'b1;
            end
        end
    end

    assign err_orphan      = err_orphan_q;
    assign err_missing_eop = err_missing_eop_q;
    assign drop_count      = drop_count_q;
`endif

endmodule

// File: tb/tb_oneapi_avalon_to_axi_gasket.sv
// Bench for oneapi_avalon_to_axi_gasket: directed scenarios plus a random stream
// checked against a queue-level model of the packet filter and 2-deep buffer.
`timescale 1ns/1ps
module tb_oneapi_avalon_to_axi_gasket;

    localparam int PP = 1, CH = 3;
    localparam int BPC_AV = 8, BPP_AV = 24, BITS_AV = 24, EMPTY_BITS = 2;
    localparam int BPC_AXI = 8, BPP_AXI = 24, BITS_AXI = 24, TUSER_BITS = 3;

    logic                  csi_clk;
    logic                  rsi_reset_n;
    logic                  asi_ready;
    logic                  asi_valid;
    logic [BITS_AV-1:0]    asi_data;
    logic                  asi_startofpacket;
    logic                  asi_endofpacket;
    logic [EMPTY_BITS-1:0] asi_empty;
    logic                  axm_tready;
    logic                  axm_tvalid;
    logic [BITS_AXI-1:0]   axm_tdata;
    logic                  axm_tlast;
    logic [TUSER_BITS-1:0] axm_tuser;
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
    logic                  err_orphan;
    logic                  err_missing_eop;
    logic [15:0]           drop_count;
`endif

    oneapi_avalon_to_axi_gasket dut (
        .csi_clk           (csi_clk),
        .rsi_reset_n       (rsi_reset_n),
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
        .err_orphan        (err_orphan),
        .err_missing_eop   (err_missing_eop),
        .drop_count        (drop_count),
`endif
        .asi_ready         (asi_ready),
        .asi_valid         (asi_valid),
        .asi_data          (asi_data),
        .asi_startofpacket (asi_startofpacket),
        .asi_endofpacket   (asi_endofpacket),
        .asi_empty         (asi_empty),
        .axm_tready        (axm_tready),
        .axm_tvalid        (axm_tvalid),
        .axm_tdata         (axm_tdata),
        .axm_tlast         (axm_tlast),
        .axm_tuser         (axm_tuser)
    );

    initial csi_clk = 1'b0;
    always #5 csi_clk = ~csi_clk;

    typedef struct packed {
        logic [BITS_AXI-1:0]   data;
        logic                  last;
        logic [TUSER_BITS-1:0] user;
    } beat_t;

    beat_t mdl_q[$];
    beat_t seen_q[$];
    int    total = 0;
    int    bad   = 0;
    int    mdl_fwd = 0;
    bit    mdl_in_pkt = 0;
    bit    mdl_ready = 0;
    bit    armed = 0;
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
    int    mdl_drops = 0;
    bit    mdl_err_or = 0;
    bit    mdl_err_me = 0;
`endif

    function automatic logic [BITS_AXI-1:0] ref_map(input logic [BITS_AV-1:0] d);
        longint unsigned r, ch, src;
        r   = 0;
        src = 64'(d);
        for (int p = 0; p < PP; p++) begin
            for (int c = 0; c < CH; c++) begin
                ch = (src >> (p*BPP_AV + c*BPC_AV)) & ((64'd1 << BPC_AV) - 64'd1);
                r  = r | (ch << (p*BPP_AXI + c*BPC_AXI));
            end
        end
        return BITS_AXI'(r);
    endfunction

    // Scoreboard: checks current outputs, then advances the model over the coming edge.
    task automatic monitor();
        beat_t b;
        bit    exp_v;
        forever begin
            @(negedge csi_clk);
            if (armed) begin
                total++;
                if (asi_ready !== mdl_ready) begin
                    bad++;
                    $display("FAIL sb_ready t=%0t actual=%b expected=%b", $time, asi_ready, mdl_ready);
                end
                exp_v = (mdl_q.size() > 0);
                total++;
                if (axm_tvalid !== exp_v) begin
                    bad++;
                    $display("FAIL sb_tvalid t=%0t actual=%b expected=%b", $time, axm_tvalid, exp_v);
                end
                if (axm_tvalid === 1'b1 && mdl_q.size() > 0) begin
                    total++;
                    if ({axm_tdata, axm_tlast, axm_tuser} !== mdl_q[0]) begin
                        bad++;
                        $display("FAIL sb_beat t=%0t actual=%h/%b/%b expected=%h/%b/%b", $time,
                                 axm_tdata, axm_tlast, axm_tuser, mdl_q[0].data, mdl_q[0].last, mdl_q[0].user);
                    end
                end
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
                total++;
                if ({err_orphan, err_missing_eop, drop_count} !== {mdl_err_or, mdl_err_me, 16'(mdl_drops)}) begin
                    bad++;
                    $display("FAIL sb_flags t=%0t actual=%b/%b/%0d expected=%b/%b/%0d", $time,
                             err_orphan, err_missing_eop, drop_count, mdl_err_or, mdl_err_me, mdl_drops);
                end
`endif
            end
            if (rsi_reset_n !== 1'b1) begin
                mdl_q.delete();
                mdl_in_pkt = 0;
                mdl_ready  = 0;
                armed      = 1;
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
                mdl_drops  = 0;
                mdl_err_or = 0;
                mdl_err_me = 0;
`endif
            end else begin
                if (axm_tvalid === 1'b1 && axm_tready === 1'b1) begin
                    seen_q.push_back({axm_tdata, axm_tlast, axm_tuser});
                    if (mdl_q.size() > 0) void'(mdl_q.pop_front());
                end
                if (asi_valid === 1'b1 && asi_ready === 1'b1) begin
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
                    if (mdl_in_pkt && asi_startofpacket) mdl_err_me = 1;
`endif
                    if (mdl_in_pkt || asi_startofpacket) begin
                        b.data = ref_map(asi_data);
                        b.last = asi_endofpacket;
                        b.user = TUSER_BITS'(asi_startofpacket);
                        mdl_q.push_back(b);
                        mdl_fwd++;
                        mdl_in_pkt = !asi_endofpacket;
                    end else begin
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
                        mdl_err_or = 1;
                        if (mdl_drops < 65535) mdl_drops++;
`endif
                    end
                end
                mdl_ready = (mdl_q.size() < 2);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge csi_clk);
            #1;
        end
    endtask

    task automatic send(input logic [BITS_AV-1:0] d, input logic s, input logic e, output int cyc);
        bit took;
        took = 0;
        cyc  = 0;
        asi_valid = 1'b1;
        asi_data = d;
        asi_startofpacket = s;
        asi_endofpacket = e;
        asi_empty = EMPTY_BITS'($urandom());
        while (!took && cyc < 40) begin
            took = (asi_ready === 1'b1);
            tick(1);
            cyc++;
        end
        asi_valid = 1'b0;
        asi_startofpacket = 1'b0;
        asi_endofpacket = 1'b0;
        total++;
        if (!took) begin
            bad++;
            $display("FAIL send_accept actual=timeout required=accepted data=%h", d);
        end
    endtask

    task automatic test_reset();
        rsi_reset_n = 1'b0;
        tick(3);
        total++;
        if ({asi_ready, axm_tvalid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_handshake actual=%b%b required=00", asi_ready, axm_tvalid);
        end
        total++;
        if ({axm_tdata, axm_tlast, axm_tuser} !== '0) begin
            bad++;
            $display("FAIL reset_payload actual=%h/%b/%b required=0", axm_tdata, axm_tlast, axm_tuser);
        end
        rsi_reset_n = 1'b1;
        tick(1);
        total++;
        if (asi_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_rise actual=%b required=1", asi_ready);
        end
    endtask

    task automatic test_line();
        logic [BITS_AV-1:0] d[4];
        int base, cyc;
        d[0] = 24'h010203; d[1] = 24'h040506; d[2] = 24'h070809; d[3] = 24'h0A0B0C;
        axm_tready = 1'b1;
        base = seen_q.size();
        for (int i = 0; i < 4; i++) begin
            send(d[i], i == 0, i == 3, cyc);
            total++;
            if (cyc !== 1) begin
                bad++;
                $display("FAIL line_throughput beat=%0d actual=%0d required=1", i, cyc);
            end
            if (i == 0) begin
                total++;
                if ({axm_tvalid, axm_tdata, axm_tuser} !== {1'b1, ref_map(d[0]), 3'b001}) begin
                    bad++;
                    $display("FAIL line_latency actual=%b/%h/%b required=1/%h/001",
                             axm_tvalid, axm_tdata, axm_tuser, ref_map(d[0]));
                end
            end
        end
        tick(3);
        total++;
        if (seen_q.size() - base !== 4) begin
            bad++;
            $display("FAIL line_count actual=%0d required=4", seen_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (seen_q[base+i] !== {ref_map(d[i]), i == 3, (i == 0) ? 3'b001 : 3'b000}) begin
                    bad++;
                    $display("FAIL line_beat%0d actual=%h/%b/%b", i,
                             seen_q[base+i].data, seen_q[base+i].last, seen_q[base+i].user);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [BITS_AV-1:0] d[6];
        int base, cyc;
        for (int i = 0; i < 6; i++) d[i] = BITS_AV'($urandom());
        axm_tready = 1'b0;
        base = seen_q.size();
        send(d[0], 1'b1, 1'b0, cyc);
        send(d[1], 1'b0, 1'b0, cyc);
        total++;
        if (asi_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_drop actual=%b required=0", asi_ready);
        end
        asi_valid = 1'b1;
        asi_data = d[2];
        tick(3);
        total++;
        if ({asi_ready, axm_tvalid, axm_tdata} !== {1'b0, 1'b1, ref_map(d[0])}) begin
            bad++;
            $display("FAIL bp_hold actual=%b/%b/%h required=0/1/%h", asi_ready, axm_tvalid, axm_tdata, ref_map(d[0]));
        end
        axm_tready = 1'b1;
        for (int i = 2; i < 6; i++) send(d[i], 1'b0, i == 5, cyc);
        tick(4);
        total++;
        if (seen_q.size() - base !== 6) begin
            bad++;
            $display("FAIL bp_count actual=%0d required=6", seen_q.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (seen_q[base+i].data !== ref_map(d[i])) begin
                    bad++;
                    $display("FAIL bp_order beat=%0d actual=%h required=%h", i, seen_q[base+i].data, ref_map(d[i]));
                end
            end
        end
    endtask

    task automatic test_orphans();
        logic [BITS_AV-1:0] d[2];
        int base, cyc;
        axm_tready = 1'b1;
        base = seen_q.size();
        for (int i = 0; i < 3; i++) send(BITS_AV'($urandom()), 1'b0, i == 2, cyc);
        d[0] = BITS_AV'($urandom());
        d[1] = BITS_AV'($urandom());
        send(d[0], 1'b1, 1'b0, cyc);
        send(d[1], 1'b0, 1'b1, cyc);
        tick(3);
        total++;
        if (seen_q.size() - base !== 2) begin
            bad++;
            $display("FAIL orphan_count actual=%0d required=2", seen_q.size() - base);
        end else begin
            total++;
            if ({seen_q[base].data, seen_q[base].user, seen_q[base+1].data, seen_q[base+1].last}
                    !== {ref_map(d[0]), 3'b001, ref_map(d[1]), 1'b1}) begin
                bad++;
                $display("FAIL orphan_line actual=%h/%b %h/%b", seen_q[base].data, seen_q[base].user,
                         seen_q[base+1].data, seen_q[base+1].last);
            end
        end
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
        total++;
        if ({drop_count, err_orphan, err_missing_eop} !== {16'd3, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL orphan_flags actual=%0d/%b/%b required=3/1/0", drop_count, err_orphan, err_missing_eop);
        end
`endif
    endtask

    task automatic test_corner();
        int base, cyc;
        axm_tready = 1'b1;
        base = seen_q.size();
        send(BITS_AV'($urandom()), 1'b1, 1'b1, cyc);
        tick(2);
        total++;
        if (seen_q.size() - base !== 1 || seen_q[base].user !== 3'b001 || seen_q[base].last !== 1'b1) begin
            bad++;
            $display("FAIL corner_sop_eop actual_count=%0d required=1 with tuser=001 tlast=1", seen_q.size() - base);
        end
        send(BITS_AV'($urandom()), 1'b1, 1'b0, cyc);
        send(BITS_AV'($urandom()), 1'b1, 1'b0, cyc);
        send(BITS_AV'($urandom()), 1'b0, 1'b1, cyc);
        tick(3);
        total++;
        if (seen_q.size() - base !== 4) begin
            bad++;
            $display("FAIL corner_count actual=%0d required=4", seen_q.size() - base);
        end else begin
            total++;
            if ({seen_q[base+2].user, seen_q[base+2].last, seen_q[base+3].user, seen_q[base+3].last}
                    !== {3'b001, 1'b0, 3'b000, 1'b1}) begin
                bad++;
                $display("FAIL corner_missing_eop_beat actual=%b/%b %b/%b", seen_q[base+2].user,
                         seen_q[base+2].last, seen_q[base+3].user, seen_q[base+3].last);
            end
        end
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
        total++;
        if (err_missing_eop !== 1'b1) begin
            bad++;
            $display("FAIL corner_err_missing_eop actual=%b required=1", err_missing_eop);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int base, cyc;
        axm_tready = 1'b0;
        send(BITS_AV'($urandom()), 1'b1, 1'b0, cyc);
        send(BITS_AV'($urandom()), 1'b0, 1'b0, cyc);
        total++;
        if ({axm_tvalid, asi_ready} !== 2'b10) begin
            bad++;
            $display("FAIL rmid_full actual=%b%b required=10", axm_tvalid, asi_ready);
        end
        rsi_reset_n = 1'b0;
        tick(1);
        total++;
        if ({axm_tvalid, asi_ready} !== 2'b00) begin
            bad++;
            $display("FAIL rmid_flush actual=%b%b required=00", axm_tvalid, asi_ready);
        end
        rsi_reset_n = 1'b1;
        tick(1);
        axm_tready = 1'b1;
        base = seen_q.size();
        send(BITS_AV'($urandom()), 1'b0, 1'b0, cyc);
        tick(3);
        total++;
        if (seen_q.size() - base !== 0 || axm_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_drop actual_count=%0d tvalid=%b required=0/0", seen_q.size() - base, axm_tvalid);
        end
`ifdef ONEAPI_A2X_PROTOCOL_CHECK_EN
        total++;
        if ({drop_count, err_orphan, err_missing_eop} !== {16'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rmid_flags actual=%0d/%b/%b required=1/1/0", drop_count, err_orphan, err_missing_eop);
        end
`endif
    endtask

    task automatic test_random();
        int base, fwd0;
        base = seen_q.size();
        fwd0 = mdl_fwd;
        for (int i = 0; i < 600; i++) begin
            asi_valid = ($urandom_range(9) < 7);
            asi_data = BITS_AV'($urandom());
            asi_startofpacket = ($urandom_range(4) == 0);
            asi_endofpacket = ($urandom_range(3) == 0);
            asi_empty = EMPTY_BITS'($urandom());
            axm_tready = ($urandom_range(3) != 0);
            tick(1);
        end
        asi_valid = 1'b0;
        asi_startofpacket = 1'b0;
        asi_endofpacket = 1'b0;
        axm_tready = 1'b1;
        tick(5);
        total++;
        if (axm_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL rand_drain actual=%b required=0", axm_tvalid);
        end
        total++;
        if (seen_q.size() - base !== mdl_fwd - fwd0) begin
            bad++;
            $display("FAIL rand_count actual=%0d required=%0d", seen_q.size() - base, mdl_fwd - fwd0);
        end
    endtask

    initial begin
        rsi_reset_n = 1'b0;
        asi_valid = 1'b0;
        asi_data = '0;
        asi_startofpacket = 1'b0;
        asi_endofpacket = 1'b0;
        asi_empty = '0;
        axm_tready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_line();
        test_backpressure();
        test_orphans();
        test_corner();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
